// File: rtl/muller_c_pkg.sv
// ---------------------------------------------------------------------------
// muller_c_pkg
//   Shared definitions for the Muller C-element driver: FSM state encoding,
//   error codes reported on err_code, and the length of the optional
//   post-transition stability window.
// ---------------------------------------------------------------------------
package muller_c_pkg;

  // HOLD_HI / HOLD_LO are only reachable when the glitch check is built in.
  typedef enum logic [3:0] {
    IDLE,
    RISE,
    WAIT_HI,
    HOLD_HI,
    FALL,
    WAIT_LO,
    HOLD_LO,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_PREMATURE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
  localparam logic [1:0] ERR_GLITCH    = 2'd3;

  // Cycles c_sync must stay stable after each observed transition.
  localparam int HOLD_CYCLES = 4;

endpackage

// File: rtl/muller_c_driver_if.sv
// ---------------------------------------------------------------------------
// muller_c_driver_if
//   Bundles the control handshake, the C-element drive/return pair and the
//   status outputs of muller_c_driver.
//   master : the controlling side (issues start, owns the C-element output)
//   slave  : muller_c_driver itself
//   Signals:
//     start        1-cycle pulse, begins a run when the driver is idle
//     num_cycles   full rise+fall cycles requested, sampled on start
//     c_out_async  asynchronous output of the C-element
//     c_drv        C-element inputs (registered in the driver)
//     busy/done    run in progress / 1-cycle completion pulse
//     error        sticky failure flag, err_code gives the reason
//     cycle_count  completed cycles of the current or last run
// ---------------------------------------------------------------------------
interface muller_c_driver_if #(
  parameter int N     = 6,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_cycles;
  logic             c_out_async;
  logic [N-1:0]     c_drv;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, num_cycles, c_out_async,
    input  c_drv, busy, done, error, err_code, cycle_count
  );

  modport slave (
    input  start, num_cycles, c_out_async,
    output c_drv, busy, done, error, err_code, cycle_count
  );
endinterface

// File: rtl/muller_sync.sv
// ---------------------------------------------------------------------------
// muller_sync
//   SYNC_STAGES-deep flop chain that brings the asynchronous C-element output
//   into the wb_clk_i domain. Cleared by the synchronous reset so that no
//   stale level from an aborted run reaches the checker.
//   Ports:
//     clk_i    clock
//     rst_i    synchronous, active-high reset
//     async_i  asynchronous input
//     sync_o   synchronised output (last stage)
// ---------------------------------------------------------------------------
module muller_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/muller_c_driver.sv
// ---------------------------------------------------------------------------
// muller_c_driver
//   Drives an N-input Muller C-element through full 4-phase cycles, one input
//   bit per clock, watches the synchronised element output and counts
//   completed cycles. Flags premature transitions, wait timeouts and, when
//   built with MULLER_C_DRIVER_GLITCH_CHECK_EN, output glitches during a
//   HOLD_CYCLES stability window after each observed transition.
//   Ports:
//     wb_clk_i  clock
//     wb_rst_i  synchronous, active-high reset (aborts any run, no done)
//     bus       muller_c_driver_if.slave (start/num_cycles/c_out_async in,
//               c_drv/busy/done/error/err_code/cycle_count out)
//   Optional macro: MULLER_C_DRIVER_GLITCH_CHECK_EN
// ---------------------------------------------------------------------------
module muller_c_driver
  import muller_c_pkg::*;
#(
  parameter int N           = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int CNT_W       = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  muller_c_driver_if.slave bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [N-1:0]     drv_q, drv_d;
  logic             error_q, error_d;
  logic [1:0]       code_q, code_d;

  logic             c_sync;
  logic [CNT_W-1:0] cnt_inc;
  logic             drive_win;
  logic             wait_win;
  logic             fail;
  logic [1:0]       fail_code;

  muller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .async_i (bus.c_out_async),
    .sync_o  (c_sync)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // c_sync during bit index k reflects the drive pattern from SYNC_STAGES+1
  // cycles earlier, so indices up to SYNC_STAGES still show the previous
  // phase's settled level. The premature check starts once the first bit
  // change of this phase can be visible.
  assign drive_win = (int'(idx_q) > SYNC_STAGES);

  // The first SYNC_STAGES cycles of a wait state still show levels caused by
  // an incomplete drive pattern; a transition seen there is premature.
  assign wait_win = (int'(tmo_q) < SYNC_STAGES);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned (which would infer a latch).
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    drv_d     = drv_q;
    error_d   = error_q;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          target_d = bus.num_cycles;
          cnt_d    = '0;
          error_d  = 1'b0;
          code_d   = ERR_NONE;
          idx_d    = '0;
          state_d  = (bus.num_cycles == '0) ? DONE : RISE;
        end
      end

      RISE: begin
        if (c_sync && drive_win) begin
          fail      = 1'b1;
          fail_code = ERR_PREMATURE;
        end else begin
          drv_d[idx_q] = 1'b1;
          if (idx_q == IDX_LAST) begin
            tmo_d   = '0;
            state_d = WAIT_HI;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      WAIT_HI: begin
        if (c_sync) begin
          if (wait_win) begin
            fail      = 1'b1;
            fail_code = ERR_PREMATURE;
          end else begin
`ifdef MULLER_C_DRIVER_GLITCH_CHECK_EN
            tmo_d   = '0;
            state_d = HOLD_HI;
`else
            idx_d   = '0;
            state_d = FALL;
`endif
          end
        end else if (&tmo_q) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      FALL: begin
        if (!c_sync && drive_win) begin
          fail      = 1'b1;
          fail_code = ERR_PREMATURE;
        end else begin
          drv_d[idx_q] = 1'b0;
          if (idx_q == IDX_LAST) begin
            tmo_d   = '0;
            state_d = WAIT_LO;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      WAIT_LO: begin
        if (!c_sync) begin
          if (wait_win) begin
            fail      = 1'b1;
            fail_code = ERR_PREMATURE;
          end else begin
`ifdef MULLER_C_DRIVER_GLITCH_CHECK_EN
            tmo_d   = '0;
            state_d = HOLD_LO;
`else
            cnt_d   = cnt_inc;
            idx_d   = '0;
            state_d = (cnt_inc == target_q) ? DONE : RISE;
`endif
          end
        end else if (&tmo_q) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

`ifdef MULLER_C_DRIVER_GLITCH_CHECK_EN
      // The timeout counter doubles as the hold counter here.
      HOLD_HI: begin
        if (!c_sync) begin
          fail      = 1'b1;
          fail_code = ERR_GLITCH;
        end else if (int'(tmo_q) == HOLD_CYCLES - 1) begin
          idx_d   = '0;
          state_d = FALL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      HOLD_LO: begin
        if (c_sync) begin
          fail      = 1'b1;
          fail_code = ERR_GLITCH;
        end else if (int'(tmo_q) == HOLD_CYCLES - 1) begin
          cnt_d   = cnt_inc;
          idx_d   = '0;
          state_d = (cnt_inc == target_q) ? DONE : RISE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif

      DONE: begin
        drv_d   = '0;
        state_d = IDLE;
      end

      ERR: begin
        drv_d   = '0;
        state_d = IDLE;
      end

      default: begin
        drv_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Any detected failure drops the drive in the same edge it enters ERR.
    if (fail) begin
      state_d = ERR;
      error_d = 1'b1;
      code_d  = fail_code;
      drv_d   = '0;
    end
  end

  // NOTE: the synchronous reset clears every register, including the
  // latched target and counters, so a mid-run reset leaves no residue.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      drv_q    <= '0;
      error_q  <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      drv_q    <= drv_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

  assign bus.c_drv       = drv_q;
  assign bus.done        = (state_q == DONE);
  assign bus.busy        = (state_q == RISE)    || (state_q == WAIT_HI) ||
                           (state_q == HOLD_HI) || (state_q == FALL)    ||
                           (state_q == WAIT_LO) || (state_q == HOLD_LO);
  assign bus.error       = error_q;
  assign bus.err_code    = code_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_muller_c_driver.sv
// ---------------------------------------------------------------------------
// tb_muller_c_driver
//   Self-checking bench for muller_c_driver. A behavioural C-element model
//   (healthy, stuck-low, early-rise or glitching) closes the loop. Expected
//   drive steps and end-of-run results are queued when a run is started and
//   compared when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_muller_c_driver;
  import muller_c_pkg::*;

  localparam int N           = 6;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_W   = 8;
  localparam int CNT_W       = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muller_c_driver_if #(.N(N), .CNT_W(CNT_W)) bus ();

  muller_c_driver #(
    .N(N), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- C-element model ----------------
  typedef enum {M_HEALTHY, M_STUCK0, M_EARLY, M_GLITCH} model_e;
  model_e mode = M_HEALTHY;
  logic   m_out = 1'b0;
  int     rise_age = 100;

  always @(negedge clk) begin
    logic prev;
    prev = m_out;
    if (rst || mode == M_STUCK0) begin
      m_out = 1'b0;
    end else begin
      if (&bus.c_drv) m_out = 1'b1;
      else if (~|bus.c_drv) m_out = 1'b0;
      if (mode == M_EARLY && bus.c_drv == 6'b000111) m_out = 1'b1;
    end
    if (m_out && !prev) rise_age = 0;
    else if (rise_age < 100) rise_age++;
    bus.c_out_async = (mode == M_GLITCH && m_out && rise_age == 2) ? 1'b0 : m_out;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic             err;
    logic [1:0]       code;
  } res_t;

  res_t         res_q[$];
  logic [N-1:0] drv_exp_q[$];
  bit           track_drv = 1'b0;
  logic [N-1:0] drv_prev = '0;
  logic         err_prev = 1'b0;
  int           done_pulses = 0;
  int           busy_seen = 0;

  always @(negedge clk) begin
    logic [N-1:0] e;
    res_t         r;
    if (track_drv && bus.c_drv !== drv_prev) begin
      e = (drv_exp_q.size() != 0) ? drv_exp_q.pop_front() : 'x;
      check("c_drv_step", bus.c_drv, e);
    end
    drv_prev = bus.c_drv;
    if (bus.done || (bus.error && !err_prev)) begin
      r = (res_q.size() != 0) ? res_q.pop_front() : 'x;
      check("cycle_count", bus.cycle_count, r.count);
      check("error", bus.error, r.err);
      check("err_code", bus.err_code, r.code);
    end
    err_prev = bus.error;
    if (bus.done) done_pulses++;
    if (bus.busy) busy_seen++;
  end

  // ---------------- helpers ----------------
  task automatic pulse_start(input logic [CNT_W-1:0] n);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_cycles = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic push_walk(input int cycles);
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin v[i] = 1'b1; drv_exp_q.push_back(v); end
      for (int i = 0; i < N; i++) begin v[i] = 1'b0; drv_exp_q.push_back(v); end
    end
  endtask

  task automatic wait_result(input string tag, input int budget);
    int n;
    n = 0;
    while (res_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check({tag, "_result_seen"}, res_q.size(), 0);
  endtask

  task automatic push_res(input int count, input logic err, input logic [1:0] code);
    res_t r;
    r.count = CNT_W'(count);
    r.err   = err;
    r.code  = code;
    res_q.push_back(r);
  endtask

  int d0, b0, n, lat;

  initial begin
    bus.start      = 1'b0;
    bus.num_cycles = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_c_drv", bus.c_drv, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_cycle_count", bus.cycle_count, 0);

    // Healthy element, three full cycles with drive walk tracking
    mode = M_HEALTHY;
    d0 = done_pulses;
    push_walk(3);
    push_res(3, 1'b0, ERR_NONE);
    track_drv = 1'b1;
    pulse_start(3);
    wait_result("healthy3", 300);
    track_drv = 1'b0;
    check("healthy3_walk_done", drv_exp_q.size(), 0);
    check("healthy3_done_pulses", done_pulses - d0, 1);
    @(negedge clk);
    check("healthy3_busy_after", bus.busy, 0);

    // Output stuck low: timeout while waiting for the rise
    mode = M_STUCK0;
    push_res(0, 1'b1, ERR_TIMEOUT);
    pulse_start(1);
    n = 0;
    while (bus.c_drv !== '1 && n < 50) begin @(negedge clk); n++; end
    check("stuck_reached_all_ones", bus.c_drv, {N{1'b1}});
    lat = 0;
    while (!bus.error && lat < 400) begin @(negedge clk); lat++; end
    check("stuck_timeout_window", (lat >= 255 && lat <= 257), 1);
    check("stuck_c_drv_zero", bus.c_drv, 0);
    check("stuck_busy_low", bus.busy, 0);
    wait_result("stuck", 10);

    // Early rise once bits 0..2 are driven
    mode = M_EARLY;
    push_res(0, 1'b1, ERR_PREMATURE);
    pulse_start(1);
    n = 0;
    while (bus.c_drv !== 6'b000111 && n < 50) begin @(negedge clk); n++; end
    check("early_saw_000111", bus.c_drv, 6'b000111);
    lat = 0;
    while (!bus.error && lat < 50) begin @(negedge clk); lat++; end
    check("early_latency_ok", (lat >= 1 && lat <= SYNC_STAGES + 1), 1);
    check("early_c_drv_zero", bus.c_drv, 0);
    wait_result("early", 10);

    // Zero-cycle request: immediate done, never busy
    mode = M_HEALTHY;
    d0 = done_pulses;
    b0 = busy_seen;
    push_res(0, 1'b0, ERR_NONE);
    pulse_start(0);
    wait_result("zero", 10);
    check("zero_busy_never", busy_seen - b0, 0);
    check("zero_done_pulses", done_pulses - d0, 1);

    // Five-cycle run with an ignored second start
    d0 = done_pulses;
    push_res(5, 1'b0, ERR_NONE);
    pulse_start(5);
    repeat (10) @(negedge clk);
    check("run5_busy_mid", bus.busy, 1);
    pulse_start(2);
    wait_result("run5", 600);
    check("run5_done_pulses", done_pulses - d0, 1);

    // Reset mid-FALL in cycle 2, then a fresh one-cycle run
    d0 = done_pulses;
    pulse_start(3);
    n = 0;
    while (!(bus.cycle_count == 1 && bus.c_drv == 6'b111100) && n < 200) begin
      @(negedge clk); n++;
    end
    check("midfall_reached", bus.c_drv, 6'b111100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_c_drv", bus.c_drv, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_error", bus.error, 0);
    check("midrst_err_code", bus.err_code, 0);
    check("midrst_cycle_count", bus.cycle_count, 0);
    repeat (60) @(negedge clk);
    check("midrst_no_done", done_pulses - d0, 0);
    push_res(1, 1'b0, ERR_NONE);
    pulse_start(1);
    wait_result("after_rst", 200);
    check("after_rst_done_pulses", done_pulses - d0, 1);

    // Short low pulse shortly after each rise
    mode = M_GLITCH;
`ifdef MULLER_C_DRIVER_GLITCH_CHECK_EN
    push_res(0, 1'b1, ERR_GLITCH);
`else
    push_res(2, 1'b0, ERR_NONE);
`endif
    pulse_start(2);
    wait_result("glitch", 300);
    mode = M_HEALTHY;

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
